// File: rtl/depacketizer_piton_rx.sv
// Rebuilds PAYLOAD_WIDTH payloads from a header + N_PKTS packet stream into a small FWFT output FIFO.
// Grant waits for FIFO space; data packets are consumed without stalls, and rejected transactions are drained then dropped.
module depacketizer_piton_rx #(
  parameter int   PAYLOAD_WIDTH = 128,
  parameter int   PACKET_WIDTH  = 16,
  parameter logic ID            = 1'b0,
  parameter int   OUT_DEPTH     = 2
) (
  input  logic                     clk_packet,
  input  logic                     rst_n,
  input  logic                     packet_req_i,
  input  logic [PACKET_WIDTH-1:0]  packet_i,
  output logic                     packet_grant_o,
  output logic                     payload_valid_o,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  input  logic                     payload_ready_i,
  output logic                     packet_received_o,
  output logic                     hdr_err_o,
  output logic [7:0]               err_count_o
);

  localparam int N_PKTS = PAYLOAD_WIDTH / PACKET_WIDTH;
  localparam int NW     = $clog2(N_PKTS) + 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW     = $clog2(OUT_DEPTH + 1);

  localparam logic [NW-1:0]    N_PKTS_C = NW'(N_PKTS);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t                   r_state;
  logic [NW-1:0]            r_cnt;
  logic                     r_drop;
  logic [PAYLOAD_WIDTH-1:0] r_payload;
  logic [7:0]               r_err_count;

  logic [PAYLOAD_WIDTH-1:0] r_mem [OUT_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic                     w_hdr_ok;
  logic                     w_grant;
  logic                     w_push;
  logic                     w_pop;
  logic [PAYLOAD_WIDTH-1:0] w_assembled;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_hdr_ok = packet_i[0] && (packet_i[1] == ID) && (packet_i[NW+1:2] == N_PKTS_C);
  assign w_grant  = rst_n && (r_state == S_IDLE) && packet_req_i && (r_count < DEPTH_C);
  assign w_pop    = rst_n && (r_count != '0) && payload_ready_i;
  assign w_push   = (r_state == S_DATA) && (r_cnt == NW'(1)) && !r_drop;

  // Shift right so the first data packet ends up in the least significant slot.
  assign w_assembled = {packet_i, r_payload[PAYLOAD_WIDTH-1:PACKET_WIDTH]};

  assign packet_grant_o    = w_grant;
  assign hdr_err_o         = w_grant && !w_hdr_ok;
  assign payload_valid_o   = rst_n && (r_count != '0);
  assign packet_received_o = w_pop;
  assign payload_o         = r_mem[r_rd_ptr];
  assign err_count_o       = r_err_count;

  always_ff @(posedge clk_packet) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_payload   <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_DATA;
            r_cnt   <= N_PKTS_C;
            r_drop  <= !w_hdr_ok;
            if (!w_hdr_ok && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
          end
        end
        S_DATA: begin
          r_payload <= w_assembled;
          r_cnt     <= r_cnt - NW'(1);
          if (r_cnt == NW'(1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Occupancy is tracked separately from the pointers so full and empty never alias.
  always_ff @(posedge clk_packet) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_assembled;
        r_wr_ptr        <= f_next(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_depacketizer_piton_rx.sv
`timescale 1ns/1ps
// Directed + randomized bench for depacketizer_piton_rx against a queue-based transaction model.
module tb_depacketizer_piton_rx;

  localparam int N     = 8;
  localparam int DEPTH = 2;

  logic         clk_packet = 1'b0;
  logic         rst_n      = 1'b0;
  logic         packet_req_i = 1'b0;
  logic [15:0]  packet_i   = '0;
  logic         payload_ready_i = 1'b0;
  logic         packet_grant_o;
  logic         payload_valid_o;
  logic [127:0] payload_o;
  logic         packet_received_o;
  logic         hdr_err_o;
  logic [7:0]   err_count_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: payloads expected in the FIFO, packets still owed, collected data.
  logic [127:0] exp_q[$];
  logic [15:0]  m_pk[$];
  int           m_left = 0;
  bit           m_drop = 0;
  int           m_err  = 0;

  depacketizer_piton_rx dut (
    .clk_packet        (clk_packet),
    .rst_n             (rst_n),
    .packet_req_i      (packet_req_i),
    .packet_i          (packet_i),
    .packet_grant_o    (packet_grant_o),
    .payload_valid_o   (payload_valid_o),
    .payload_o         (payload_o),
    .payload_ready_i   (payload_ready_i),
    .packet_received_o (packet_received_o),
    .hdr_err_o         (hdr_err_o),
    .err_count_o       (err_count_o)
  );

  always #5 clk_packet = ~clk_packet;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit hdr_bad(input logic [15:0] h);
    int n;
    n = (h >> 2) & 16'hF;
    return !(h[0] == 1'b1 && h[1] == 1'b0 && n == N);
  endfunction

  function automatic logic [127:0] assemble();
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p = p | (128'(m_pk[i]) << (16 * i));
    return p;
  endfunction

  function automatic logic rbit(input int code);
    return (code == 2) ? logic'($urandom_range(0, 1)) : logic'(code != 0);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pk.delete();
    m_left = 0;
    m_drop = 0;
    m_err  = 0;
  endtask

  // One clock cycle: drive, check against the model, advance the model across the edge.
  task automatic cycle(input logic req, input logic [15:0] pkt, input logic rdy, output logic g);
    logic e_grant, e_valid, e_recv;
    bit bad;
    packet_req_i    = req;
    packet_i        = pkt;
    payload_ready_i = rdy;
    #1;
    bad     = hdr_bad(pkt);
    e_valid = exp_q.size() > 0;
    e_grant = (m_left == 0) && req && (exp_q.size() < DEPTH);
    e_recv  = e_valid && rdy;
    chk("grant", packet_grant_o, e_grant);
    chk("valid", payload_valid_o, e_valid);
    chk("received", packet_received_o, e_recv);
    chk("hdr_err", hdr_err_o, e_grant && bad);
    chk("err_count", err_count_o, m_err);
    if (e_valid) chk("payload", payload_o, exp_q[0]);
    if (e_recv) void'(exp_q.pop_front());
    if (m_left == 0) begin
      if (e_grant) begin
        m_left = N;
        m_drop = bad;
        m_pk.delete();
        if (bad && m_err < 255) m_err++;
      end
    end else begin
      m_pk.push_back(pkt);
      m_left--;
      if (m_left == 0 && !m_drop) exp_q.push_back(assemble());
    end
    g = e_grant;
    @(posedge clk_packet);
    #1;
  endtask

  // Request until granted, then send n_data packets (req deliberately held high throughout).
  task automatic txn(input logic [15:0] hdr, input int rw, input int rd, input int rl,
                     input bit seq, input int n_data);
    logic g;
    int k;
    g = 1'b0;
    k = 0;
    while (!g && k < 40) begin
      cycle(1'b1, hdr, rbit(rw), g);
      k++;
    end
    if (!g) begin
      n_assert++;
      n_fail++;
      $error("FAIL grant_timeout got none exp grant within 40 cycles");
    end
    for (int i = 0; i < n_data; i++)
      cycle(1'b1, seq ? 16'(i) : 16'($urandom), (i == N - 1) ? rbit(rl) : rbit(rd), g);
  endtask

  task automatic idle(input int n, input int rdy);
    logic g;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), rbit(rdy), g);
  endtask

  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    packet_req_i = 1'b0;
    repeat (n) @(posedge clk_packet);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] make_bad();
    logic [15:0] h;
    h = 16'h0021 | (16'($urandom) & 16'hFFC0);
    case ($urandom_range(0, 2))
      0:       h[0] = 1'b0;
      1:       h[1] = 1'b1;
      default: h[5:2] = 4'(N + 1 + $urandom_range(0, 6));
    endcase
    return h;
  endfunction

  initial begin
    logic g;

    // Reset state
    do_reset(2);
    chk("rst_grant", packet_grant_o, 1'b0);
    chk("rst_valid", payload_valid_o, 1'b0);
    chk("rst_received", packet_received_o, 1'b0);
    chk("rst_hdr_err", hdr_err_o, 1'b0);
    chk("rst_err_count", err_count_o, 8'd0);
    chk("rst_payload", payload_o, 128'd0);
    idle(2, 1);

    // Single payload with data 0..7
    txn(16'h0021, 1, 1, 1, 1'b1, N);
    packet_req_i    = 1'b0;
    payload_ready_i = 1'b1;
    #1;
    chk("single_valid", payload_valid_o, 1'b1);
    chk("single_payload", payload_o, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("single_received", packet_received_o, 1'b1);
    idle(3, 1);

    // Bad header, then a good transaction
    txn(16'h0023, 1, 1, 1, 1'b0, N);
    chk("bad_err_count", err_count_o, 8'd1);
    chk("bad_no_push", payload_valid_o, 1'b0);
    txn(16'h0021, 1, 1, 1, 1'b0, N);
    idle(3, 1);

    // Backpressure: two stored, third waits until the first pop
    txn(16'h0021, 0, 0, 0, 1'b0, N);
    txn(16'h0021, 0, 0, 0, 1'b0, N);
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0021, 1'b0, g);
    txn(16'h0021, 1, 1, 1, 1'b0, N);
    idle(4, 1);

    // Simultaneous push and pop with one entry held
    txn(16'h0021, 0, 0, 0, 1'b0, N);
    txn(16'h0021, 0, 0, 1, 1'b0, N);
    chk("pushpop_valid", payload_valid_o, 1'b1);
    idle(2, 0);
    idle(3, 1);

    // Reset mid-transaction with a stored payload
    txn(16'h0021, 0, 0, 0, 1'b0, N);
    txn(16'h0021, 0, 0, 0, 1'b0, 3);
    do_reset(1);
    payload_ready_i = 1'b1;
    #1;
    chk("mid_rst_valid", payload_valid_o, 1'b0);
    chk("mid_rst_grant", packet_grant_o, 1'b0);
    chk("mid_rst_received", packet_received_o, 1'b0);
    chk("mid_rst_hdr_err", hdr_err_o, 1'b0);
    chk("mid_rst_err_count", err_count_o, 8'd0);
    chk("mid_rst_payload", payload_o, 128'd0);
    idle(2, 1);
    txn(16'h0021, 1, 1, 1, 1'b0, N);
    idle(3, 1);

    // Randomized traffic and ready
    for (int t = 0; t < 30; t++) begin
      txn(($urandom_range(0, 4) == 0) ? make_bad() : 16'h0021, 2, 2, 2, 1'b0, N);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 2);
    end
    idle(6, 1);

    // Error counter saturation
    for (int t = 0; t < 260; t++) txn(make_bad(), 1, 1, 1, 1'b0, N);
    idle(1, 1);
    chk("sat_err_count", err_count_o, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/depacketizer_piton_rx.md
# depacketizer_piton_rx

Receive-side reassembler that consumes the serialized packet stream produced by the core-side packetizer and rebuilds full payloads. It issues one grant per transaction, checks the header, and shifts N data packets into a payload register. Completed payloads go into a small output FIFO with a valid/ready handshake toward the L2-side consumer. It also returns a one-cycle `packet_received_o` pulse per delivered payload, which drives the packetizer's outstanding-request throttle.

## Interface
- `PAYLOAD_WIDTH`, 128: reassembled payload width; must be a multiple of `PACKET_WIDTH`.
- `PACKET_WIDTH`, 16: width of one serialized packet.
- `ID`, 0: 1-bit source ID accepted in the header.
- `OUT_DEPTH`, 2: output FIFO entries, 1..4.
- Derived: `N_PKTS = PAYLOAD_WIDTH/PACKET_WIDTH`; `NW = ceil(log2(N_PKTS)) + 1` (4 for defaults).
- `clk_packet`  in  1  packet-domain clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `packet_req_i`  in  1  upstream has a complete payload queued.
- `packet_i`  in  PACKET_WIDTH  header or data packet.
- `packet_grant_o`  out  1  one-cycle grant; starts a transaction.
- `payload_valid_o`  out  1  FIFO head valid.
- `payload_o`  out  PAYLOAD_WIDTH  FIFO head (first-word fall-through).
- `payload_ready_i`  in  1  consumer accepts the head.
- `packet_received_o`  out  1  pulse on each payload pop.
- `hdr_err_o`  out  1  pulse on header rejection.
- `err_count_o`  out  8  saturating count of rejected headers.

## Operation
- Header format: bit0 = 1 (valid), bit1 = id, bits[NW+1:2] = n_pkts; upper bits ignored. Default good header with ID=0 is 0x0021.
- A header is rejected if any of these fail: valid bit = 1, id == ID, n_pkts == N_PKTS.
- FSM states:
  - IDLE: when `packet_req_i` and FIFO count < OUT_DEPTH, assert `packet_grant_o` for that cycle and sample `packet_i` as the header in the same cycle. Then go to DATA, with cnt = N_PKTS and drop = header rejected.
  - DATA: each cycle, shift `packet_i` into the payload register, LSB-first. The first data packet lands in payload[PACKET_WIDTH-1:0]. Decrement cnt. When cnt == 1, go to IDLE and, if !drop, push the assembled payload into the FIFO on that same edge.
- Rejected header: `hdr_err_o` pulses in the header cycle. `err_count_o` increments and saturates at 255. The N_PKTS data packets are still consumed, then discarded, so the stream stays aligned. No push and no `packet_received_o` for that transaction.
- `packet_req_i` is ignored outside IDLE. Only one grant is issued per transaction.
- Data packets are consumed unconditionally; the upstream block must not stall mid-transaction.
- FIFO pop occurs when `payload_valid_o` and `payload_ready_i`. `packet_received_o` is high in the same cycle as the pop.
- Push and pop in the same cycle: count is unchanged and both take effect. Push into a full FIFO cannot occur, because grant requires free space and count cannot rise during a transaction.
- Pointers wrap modulo OUT_DEPTH. The count is held separately, so full and empty are unambiguous.

## Timing
- Reset values while `rst_n` = 0 at an edge:
  - state IDLE, cnt 0, drop 0, FIFO count 0.
  - `packet_grant_o`, `payload_valid_o`, `packet_received_o`, `hdr_err_o` = 0; `err_count_o` = 0; `payload_o` = 0.
- Reset mid-transaction discards the partial payload and all FIFO contents. After reset release the block expects a fresh header.
- Transaction length: grant/header in cycle T, data in T+1..T+N_PKTS.
- `payload_valid_o` rises in cycle T+N_PKTS+1, assuming the FIFO was empty.
- The earliest next grant is T+N_PKTS+1, giving a peak of one payload per N_PKTS+1 cycles.
- `packet_grant_o`, `packet_received_o` and `payload_valid_o` are combinational from state, count and inputs; `hdr_err_o` is combinational in the header cycle. All datapath state is registered.

## Test plan
- Single payload:
  - Stimulus: req high in IDLE; header 0x0021; data 0x0000..0x0007 in T+1..T+8; ready high.
  - Required: one grant pulse at T; `payload_valid_o` at T+9 with `payload_o` = 0x0007000600050004000300020001_0000; `packet_received_o` pulses at T+9.
- Bad header:
  - Stimulus: header 0x0023 (id = 1 with ID = 0), then 8 data packets.
  - Required: `hdr_err_o` pulses at T; `err_count_o` = 1; no FIFO push; the next good transaction reassembles correctly.
- Backpressure:
  - Stimulus: ready low, 3 back-to-back requests.
  - Required: 2 payloads stored; no third grant while count = 2. After ready goes high, the first pop frees a slot, the next IDLE cycle grants, and payloads come out in order.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 1 entry; ready pulses exactly on the push edge of a second payload.
  - Required: count stays 1, one `packet_received_o` pulse, and the head becomes the new payload.
- Reset mid-transaction:
  - Stimulus: `rst_n` low at T+4 for one cycle, then a full good transaction.
  - Required: all outputs 0 at T+5, no partial payload emitted, and the new payload is correct.
- Error saturation:
  - Stimulus: 260 bad headers.
  - Required: `err_count_o` holds at 255.
